// File: rtl/inst_fetch_queue.sv
// ============================================================================
// Module      : inst_fetch_queue
// Description : Writable program store with an auto-incrementing fetch engine,
//               a prefetch queue and a valid/ready decode interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_queue #(
  parameter int ADDR_W = 8,
  parameter int OPC_W  = 5,
  parameter int REG_W  = 4,
  parameter int IMM_W  = 8,
  parameter int QDEPTH = 4,
  localparam int INST_W = OPC_W + 3*REG_W + IMM_W,
  localparam int CNT_W  = $clog2(QDEPTH) + 1
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              Enable,
  input  logic              Prog_we,
  input  logic [ADDR_W-1:0] Prog_addr,
  input  logic [INST_W-1:0] Prog_data,
  input  logic              Branch_valid,
  input  logic [ADDR_W-1:0] Branch_target,
  input  logic              Inst_ready,
  output logic              Inst_valid,
  output logic [INST_W-1:0] Dataout,
  output logic [ADDR_W-1:0] Inst_pc,
  output logic [OPC_W-1:0]  opcode,
  output logic [REG_W-1:0]  Destin,
  output logic [REG_W-1:0]  Source1,
  output logic [REG_W-1:0]  Source2,
  output logic [IMM_W-1:0]  Imm,
  output logic [CNT_W-1:0]  Queue_count
);

  localparam int PTR_W = $clog2(QDEPTH);

  logic [INST_W-1:0] mem_q [2**ADDR_W];
  logic [INST_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] rd_pc_q;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic [INST_W-1:0] qdata_q [QDEPTH];
  logic [ADDR_W-1:0] qpc_q   [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [INST_W-1:0] last_data_q;
  logic [ADDR_W-1:0] last_pc_q;

  logic              w_pop, w_push, w_issue;
  logic [CNT_W-1:0]  w_occ;

  // Space check counts the outstanding read but not a same-edge pop.
  assign w_occ   = count_q + CNT_W'(inflight_q);
  assign w_issue = Enable && !Branch_valid && (w_occ < CNT_W'(QDEPTH));
  assign w_push  = inflight_q && !Branch_valid;
  assign w_pop   = (count_q != '0) && Inst_ready;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = w_issue;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (Branch_valid) begin
      pc_d     = Branch_target;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_issue) pc_d     = pc_q + 1'b1;
      if (w_push)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q        <= '0;
      inflight_q  <= 1'b0;
      rd_pc_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_data_q <= '0;
      last_pc_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (w_issue) rd_pc_q <= pc_q;
      if (w_pop) begin
        last_data_q <= qdata_q[rd_ptr_q];
        last_pc_q   <= qpc_q[rd_ptr_q];
      end
    end
  end

  // Store and queue payloads carry no reset; validity lives in the control state.
  always_ff @(posedge clk) begin
    if (Prog_we) mem_q[Prog_addr] <= Prog_data;
    if (w_issue) rd_data_q <= mem_q[pc_q];
    if (w_push) begin
      qdata_q[wr_ptr_q] <= rd_data_q;
      qpc_q[wr_ptr_q]   <= rd_pc_q;
    end
  end

  assign Inst_valid  = (count_q != '0);
  assign Dataout     = Inst_valid ? qdata_q[rd_ptr_q] : last_data_q;
  assign Inst_pc     = Inst_valid ? qpc_q[rd_ptr_q]   : last_pc_q;
  assign Queue_count = count_q;

  assign opcode  = Dataout[INST_W-1 -: OPC_W];
  assign Destin  = Dataout[INST_W-OPC_W-1 -: REG_W];
  assign Source1 = Dataout[INST_W-OPC_W-REG_W-1 -: REG_W];
  assign Source2 = Dataout[INST_W-OPC_W-2*REG_W-1 -: REG_W];
  assign Imm     = Dataout[IMM_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// ============================================================================
// Module      : tb_inst_fetch_queue
// Description : Directed self-checking bench for inst_fetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_queue;

  logic        clk;
  logic        Reset_n;
  logic        Enable;
  logic        Prog_we;
  logic [7:0]  Prog_addr;
  logic [24:0] Prog_data;
  logic        Branch_valid;
  logic [7:0]  Branch_target;
  logic        Inst_ready;
  logic        Inst_valid;
  logic [24:0] Dataout;
  logic [7:0]  Inst_pc;
  logic [4:0]  opcode;
  logic [3:0]  Destin;
  logic [3:0]  Source1;
  logic [3:0]  Source2;
  logic [7:0]  Imm;
  logic [2:0]  Queue_count;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [24:0] SPEC_W = 25'b00011_0010_0100_0110_11110000;
  localparam logic [24:0] NEW_W  = {5'd17, 4'd9, 4'd10, 4'd11, 8'h3C};

  inst_fetch_queue dut (
    .clk          (clk),
    .Reset_n      (Reset_n),
    .Enable       (Enable),
    .Prog_we      (Prog_we),
    .Prog_addr    (Prog_addr),
    .Prog_data    (Prog_data),
    .Branch_valid (Branch_valid),
    .Branch_target(Branch_target),
    .Inst_ready   (Inst_ready),
    .Inst_valid   (Inst_valid),
    .Dataout      (Dataout),
    .Inst_pc      (Inst_pc),
    .opcode       (opcode),
    .Destin       (Destin),
    .Source1      (Source1),
    .Source2      (Source2),
    .Imm          (Imm),
    .Queue_count  (Queue_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [24:0] word(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {b[4:0], b[3:0], ~b[3:0], b[7:4], b ^ 8'hA5};
  endfunction

  function automatic logic [24:0] exp_w(input int a);
    return (a == 3) ? SPEC_W : word(a);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input int pc);
    chk({tag, " valid"}, 32'(Inst_valid), 32'd1);
    chk({tag, " pc"},    32'(Inst_pc),    32'(pc[7:0]));
    chk({tag, " data"},  32'(Dataout),    32'(exp_w(pc)));
  endtask

  initial begin
    Reset_n = 1'b0; Enable = 1'b0; Prog_we = 1'b0; Prog_addr = '0; Prog_data = '0;
    Branch_valid = 1'b0; Branch_target = '0; Inst_ready = 1'b0;
    step();
    step();
    Reset_n = 1'b1;

    for (int a = 0; a < 256; a++) begin
      Prog_we = 1'b1; Prog_addr = 8'(a); Prog_data = exp_w(a);
      step();
    end
    Prog_we = 1'b0;

    chk("idle valid", 32'(Inst_valid),  32'd0);
    chk("idle count", 32'(Queue_count), 32'd0);
    chk("idle data",  32'(Dataout),     32'd0);
    chk("idle pc",    32'(Inst_pc),     32'd0);

    // Streaming from PC 0.
    Enable = 1'b1; Inst_ready = 1'b1;
    step();
    chk("first edge valid", 32'(Inst_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk_head("stream", k);
      if (k == 3) begin
        chk("stream count", 32'(Queue_count), 32'd1);
        chk("opcode",  32'(opcode),  32'd3);
        chk("Destin",  32'(Destin),  32'd2);
        chk("Source1", 32'(Source1), 32'd4);
        chk("Source2", 32'(Source2), 32'd6);
        chk("Imm",     32'(Imm),     32'hF0);
      end
    end

    // Stall until three entries are held, then reset mid-stream.
    Inst_ready = 1'b0;
    step();
    step();
    chk("pre-reset count", 32'(Queue_count), 32'd3);
    Reset_n = 1'b0;
    #1;
    chk("rst valid",  32'(Inst_valid),  32'd0);
    chk("rst count",  32'(Queue_count), 32'd0);
    chk("rst data",   32'(Dataout),     32'd0);
    chk("rst pc",     32'(Inst_pc),     32'd0);
    chk("rst opcode", 32'(opcode),      32'd0);
    chk("rst imm",    32'(Imm),         32'd0);
    step();
    Reset_n = 1'b1;

    // Backpressure: queue saturates and issue stops.
    step();
    chk("bp first valid", 32'(Inst_valid), 32'd0);
    for (int i = 0; i < 9; i++) step();
    chk("bp count", 32'(Queue_count), 32'd4);
    chk_head("bp head", 0);

    Inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk_head("drain", k);
      step();
    end
    chk_head("pre-branch", 5);

    // Redirect in the same edge as the pop of PC 5.
    Branch_valid = 1'b1; Branch_target = 8'h40;
    step();
    Branch_valid = 1'b0;
    chk("br valid",     32'(Inst_valid),  32'd0);
    chk("br count",     32'(Queue_count), 32'd0);
    chk("br hold pc",   32'(Inst_pc),     32'd5);
    chk("br hold data", 32'(Dataout),     32'(exp_w(5)));
    step();
    chk("br+1 valid", 32'(Inst_valid), 32'd0);
    step();
    chk_head("br target", 'h40);
    step();
    chk_head("br next", 'h41);

    // PC wrap at the top of the store.
    Branch_valid = 1'b1; Branch_target = 8'hFE;
    step();
    Branch_valid = 1'b0;
    step();
    step();
    chk_head("wrap", 'hFE);
    step();
    chk_head("wrap", 'hFF);
    step();
    chk_head("wrap", 'h00);
    step();
    chk_head("wrap", 'h01);

    // Write to the address being read in the same edge.
    Branch_valid = 1'b1; Branch_target = 8'h80;
    step();
    Branch_valid = 1'b0;
    Prog_we = 1'b1; Prog_addr = 8'h80; Prog_data = NEW_W;
    step();
    Prog_we = 1'b0;
    step();
    chk_head("hazard old", 'h80);
    Branch_valid = 1'b1;
    step();
    Branch_valid = 1'b0;
    step();
    step();
    chk("refetch pc",     32'(Inst_pc), 32'h80);
    chk("refetch data",   32'(Dataout), 32'(NEW_W));
    chk("refetch opcode", 32'(opcode),  32'd17);

    // Enable low: in-flight fill completes and the queue drains.
    Enable = 1'b0;
    step();
    step();
    step();
    chk("drain valid", 32'(Inst_valid),  32'd0);
    chk("drain count", 32'(Queue_count), 32'd0);
    chk("drain hold",  32'(Inst_pc),     32'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
